// File: rtl/sipo_pkg.sv
// Shared types for the framed serial-to-parallel stream (sipo_stream).
// Build option SIPO_LSB_FIRST_EN (see sipo_stream) does not affect anything here.
`ifndef SIPO_PKG_SV
`define SIPO_PKG_SV

// FIFO entry: frame-end tag above the data word, so {last,data} packs to W+1 bits.
`define SIPO_ENTRY_T(WIDTH) struct packed {logic last; logic [(WIDTH)-1:0] data;}

package sipo_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Occupancy counter width: must represent 0..DEPTH inclusive.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

`endif

// File: rtl/sipo_fifo.sv
// Show-ahead synchronous FIFO of {last,data} entries for sipo_stream.
// A push while full is accepted only when a pop happens on the same edge.
module sipo_fifo
    import sipo_pkg::*;
#(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W:0]   push_data,
    output logic         full,
    input  logic         pop,
    output logic [W:0]   head,
    output logic         empty
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = cnt_w(DEPTH);

    logic [W:0]       mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // When full, the slot being written is the one being popped this edge.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/sipo_stream.sv
// Framed serial stream deserialiser with FIFO-buffered ready/valid output.
// Build option SIPO_LSB_FIRST_EN: first received bit lands in m_data[0] instead of the MSB.
module sipo_stream
    import sipo_pkg::*;
#(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cs,
    input  logic         sdi,
    output logic [W-1:0] m_data,
    output logic         m_last,
    output logic         m_valid,
    input  logic         m_ready,
    output logic         frag_err,
    output logic         overflow
);

    typedef `SIPO_ENTRY_T(W) entry_t;

    localparam int BW = $clog2(W);

    state_t        state;
    logic [W-1:0]  sr;
    logic [W-1:0]  sr_next;
    logic [W-1:0]  pend;
    logic          pend_v;
    logic [BW-1:0] bit_cnt;
    logic          word_done;
    logic          close;
    logic          push;
    entry_t        push_entry;
    logic [W:0]    head_raw;
    entry_t        head;
    logic          full;
    logic          empty;
    logic          pop;

    always_comb begin
`ifdef SIPO_LSB_FIRST_EN
        sr_next = {sdi, sr[W-1:1]};
`else
        sr_next = {sr[W-2:0], sdi};
`endif
    end

    assign word_done = cs && (bit_cnt == BW'(W - 1));
    assign close     = (state == SHIFT) && !cs;

    // Completed words wait in pend so the frame's final word can be tagged last at close.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            sr         <= '0;
            bit_cnt    <= '0;
            pend       <= '0;
            pend_v     <= 1'b0;
            push       <= 1'b0;
            push_entry <= '0;
            frag_err   <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            push     <= 1'b0;
            frag_err <= 1'b0;

            if (push && full && !pop) begin
                overflow <= 1'b1;
            end

            case (state)
                IDLE:    if (cs)  state <= SHIFT;
                SHIFT:   if (!cs) state <= IDLE;
                default: state <= IDLE;
            endcase

            if (cs) begin
                sr <= sr_next;
                if (word_done) begin
                    bit_cnt <= '0;
                    if (pend_v) begin
                        push       <= 1'b1;
                        push_entry <= '{last: 1'b0, data: pend};
                    end
                    pend   <= sr_next;
                    pend_v <= 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end else if (close) begin
                if (pend_v) begin
                    push       <= 1'b1;
                    push_entry <= '{last: 1'b1, data: pend};
                    pend_v     <= 1'b0;
                end
                frag_err <= (bit_cnt != '0);
                bit_cnt  <= '0;
            end
        end
    end

    sipo_fifo #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_entry),
        .full      (full),
        .pop       (pop),
        .head      (head_raw),
        .empty     (empty)
    );

    assign head    = head_raw;
    assign pop     = !empty && m_ready;
    assign m_valid = !empty;
    assign m_data  = empty ? '0 : head.data;
    assign m_last  = !empty && head.last;

endmodule
